// File: rtl/mmio_arbiter_if.sv
// One valid/ready MMIO bus segment. The arbiter takes two master-facing
// segments through the slave modport and drives the peripheral segment through the master modport.
interface mmio_arbiter_if;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;

    modport master (output valid, addr, wdata, wstrb, input ready, rdata);
    modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin arbiter for two MMIO masters sharing one peripheral bus.
// Each transfer is latched onto the slave side; a hung slave is aborted after TIMEOUT cycles.
//
// state | meaning
// IDLE  | no transfer; arbitrate between the pending requests
// BUSY  | latched request presented on s_*, waiting for s_ready or timeout
// RESP  | one-cycle ready pulse to the owner, then back to IDLE
module mmio_arbiter #(
    parameter int unsigned TIMEOUT   = 1024,
    parameter logic [31:0] ERR_RDATA = 32'hFFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rst,
    mmio_arbiter_if.slave         m0_bus,
    mmio_arbiter_if.slave         m1_bus,
    mmio_arbiter_if.master        s_bus,
    output logic [1:0]            grant,
    output logic                  err,
    output logic [7:0]            err_count
);
    localparam int unsigned     CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_RESP} state_t;

    state_t        state_q, state_d;
    logic          last_q, last_d;      // 1 = m1 owned the previous transfer
    logic [1:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          s_valid_q, s_valid_d;
    logic [31:0]   s_addr_q, s_addr_d;
    logic [31:0]   s_wdata_q, s_wdata_d;
    logic [3:0]    s_wstrb_q, s_wstrb_d;
    logic          m0_ready_q, m0_ready_d;
    logic          m1_ready_q, m1_ready_d;
    logic [31:0]   m0_rdata_q, m0_rdata_d;
    logic [31:0]   m1_rdata_q, m1_rdata_d;
    logic          err_q, err_d;
    logic [7:0]    err_count_q, err_count_d;
    logic          pick_m1;
    logic          done;
    logic [31:0]   rd_val;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        s_valid_d   = s_valid_q;
        s_addr_d    = s_addr_q;
        s_wdata_d   = s_wdata_q;
        s_wstrb_d   = s_wstrb_q;
        m0_ready_d  = 1'b0;
        m1_ready_d  = 1'b0;
        m0_rdata_d  = m0_rdata_q;
        m1_rdata_d  = m1_rdata_q;
        err_d       = 1'b0;
        err_count_d = err_count_q;
        pick_m1     = 1'b0;
        done        = 1'b0;
        rd_val      = s_bus.rdata;

        unique case (state_q)
            ST_IDLE: begin
                // On contention the master that did not win last time goes first.
                pick_m1 = m1_bus.valid && (!m0_bus.valid || !last_q);
                if (m0_bus.valid || m1_bus.valid) begin
                    s_addr_d  = pick_m1 ? m1_bus.addr  : m0_bus.addr;
                    s_wdata_d = pick_m1 ? m1_bus.wdata : m0_bus.wdata;
                    s_wstrb_d = pick_m1 ? m1_bus.wstrb : m0_bus.wstrb;
                    s_valid_d = 1'b1;
                    grant_d   = {pick_m1, !pick_m1};
                    last_d    = pick_m1;
                    cnt_d     = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_bus.ready) begin
                    done = 1'b1;
                end else if (cnt_q == CNT_LAST) begin
                    done   = 1'b1;
                    rd_val = ERR_RDATA;
                    err_d  = 1'b1;
                    if (err_count_q != 8'hFF) begin
                        err_count_d = err_count_q + 8'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (done) begin
                    s_valid_d = 1'b0;
                    state_d   = ST_RESP;
                    if (grant_q[1]) begin
                        m1_ready_d = 1'b1;
                        m1_rdata_d = rd_val;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_rdata_d = rd_val;
                    end
                end
            end
            ST_RESP: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_q      <= 1'b1;
            grant_q     <= '0;
            cnt_q       <= '0;
            s_valid_q   <= 1'b0;
            s_addr_q    <= '0;
            s_wdata_q   <= '0;
            s_wstrb_q   <= '0;
            m0_ready_q  <= 1'b0;
            m1_ready_q  <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            s_valid_q   <= s_valid_d;
            s_addr_q    <= s_addr_d;
            s_wdata_q   <= s_wdata_d;
            s_wstrb_q   <= s_wstrb_d;
            m0_ready_q  <= m0_ready_d;
            m1_ready_q  <= m1_ready_d;
            m0_rdata_q  <= m0_rdata_d;
            m1_rdata_q  <= m1_rdata_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign s_bus.valid   = s_valid_q;
    assign s_bus.addr    = s_addr_q;
    assign s_bus.wdata   = s_wdata_q;
    assign s_bus.wstrb   = s_wstrb_q;
    assign m0_bus.ready  = m0_ready_q;
    assign m0_bus.rdata  = m0_rdata_q;
    assign m1_bus.ready  = m1_ready_q;
    assign m1_bus.rdata  = m1_rdata_q;
    assign grant         = grant_q;
    assign err           = err_q;
    assign err_count     = err_count_q;
endmodule

// File: tb/tb_mmio_arbiter.sv
// Bench for mmio_arbiter: directed timing scenarios plus randomized traffic
// checked against a transaction-level model of arbitration, slave latency and timeout.
module tb_mmio_arbiter;
    localparam int          TO   = 8;
    localparam logic [31:0] ERRD = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] grant;
    logic       err;
    logic [7:0] err_count;

    always #5 clk = ~clk;

    mmio_arbiter_if m0_bus();
    mmio_arbiter_if m1_bus();
    mmio_arbiter_if s_bus();

    mmio_arbiter #(.TIMEOUT(TO), .ERR_RDATA(ERRD)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_bus    (m0_bus),
        .m1_bus    (m1_bus),
        .s_bus     (s_bus),
        .grant     (grant),
        .err       (err),
        .err_count (err_count)
    );

    int          checks   = 0;
    int          failures = 0;
    req_t        q0[$];
    req_t        q1[$];
    int          lastw;
    int          errs;
    logic [31:0] rd_model[2];
    int          rdy_cnt[2];
    int          grant_log[$];

    function automatic req_t head(input int m);
        return (m == 1) ? q1[0] : q0[0];
    endfunction

    function automatic logic rdy(input int m);
        return (m == 1) ? m1_bus.ready : m0_bus.ready;
    endfunction

    function automatic logic [31:0] rdv(input int m);
        return (m == 1) ? m1_bus.rdata : m0_bus.rdata;
    endfunction

    function automatic logic [7:0] exp_errcnt();
        return (errs > 255) ? 8'hFF : 8'(errs);
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.addr  = 32'h1000_0000 | ($urandom & 32'h0000_0FFC);
        r.wdata = $urandom;
        r.wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        m0_bus.valid = 1'b0; m0_bus.addr = '0; m0_bus.wdata = '0; m0_bus.wstrb = '0;
        m1_bus.valid = 1'b0; m1_bus.addr = '0; m1_bus.wdata = '0; m1_bus.wstrb = '0;
        s_bus.ready  = 1'b0; s_bus.rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        lastw = 1; errs = 0;
        rd_model[0] = '0; rd_model[1] = '0;
        q0.delete(); q1.delete();
    endtask

    task automatic drive_masters(input bit gaps);
        m0_bus.valid = (q0.size() > 0) && (!gaps || $urandom_range(3) != 0);
        if (q0.size() > 0) begin
            m0_bus.addr = q0[0].addr; m0_bus.wdata = q0[0].wdata; m0_bus.wstrb = q0[0].wstrb;
        end
        m1_bus.valid = (q1.size() > 0) && (!gaps || $urandom_range(3) != 0);
        if (q1.size() > 0) begin
            m1_bus.addr = q1[0].addr; m1_bus.wdata = q1[0].wdata; m1_bus.wstrb = q1[0].wstrb;
        end
    endtask

    // Transaction-level engine: slave latency lat >= TO means the slave never answers.
    task automatic run_traffic(input int minlat, input int maxlat, input bit gaps,
                               input bit fix_en, input logic [31:0] fix_val, input int budget);
        bit          busy = 0, resp_due = 0, resp_err = 0, s0, s1;
        int          cur = 0, bidx = 0, lat = 0, cyc = 0;
        logic [31:0] exp_rd = '0;
        req_t        h;
        s_bus.ready = 1'b0;
        drive_masters(gaps);
        while ((q0.size() > 0 || q1.size() > 0 || busy || resp_due) && cyc < budget) begin
            s0 = m0_bus.valid;
            s1 = m1_bus.valid;
            @(posedge clk);
            #1;
            cyc++;
            if (resp_due) begin
                checks++;
                if (rdy(cur) !== 1'b1 || rdv(cur) !== exp_rd)
                    $display("FAIL resp m%0d: ready=%b rdata=%h, want ready=1 rdata=%h", cur, rdy(cur), rdv(cur), exp_rd);
                if (rdy(cur) !== 1'b1 || rdv(cur) !== exp_rd) failures++;
                checks++;
                if (rdy(1 - cur) !== 1'b0 || rdv(1 - cur) !== rd_model[1 - cur]) begin
                    failures++;
                    $display("FAIL other m%0d: ready=%b rdata=%h, want ready=0 rdata=%h",
                             1 - cur, rdy(1 - cur), rdv(1 - cur), rd_model[1 - cur]);
                end
                checks++;
                if (err !== resp_err || err_count !== exp_errcnt() || s_bus.valid !== 1'b0) begin
                    failures++;
                    $display("FAIL resp_err: err=%b cnt=%0d s_valid=%b, want err=%b cnt=%0d s_valid=0",
                             err, err_count, s_bus.valid, resp_err, exp_errcnt());
                end
                rd_model[cur] = exp_rd;
                rdy_cnt[cur]++;
                if (cur == 1) void'(q1.pop_front()); else void'(q0.pop_front());
                resp_due = 0;
            end else begin
                checks++;
                if (m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0 || err !== 1'b0) begin
                    failures++;
                    $display("FAIL spurious: m0_ready=%b m1_ready=%b err=%b, want 0 0 0",
                             m0_bus.ready, m1_bus.ready, err);
                end
                if (busy) begin
                    bidx++;
                    h = head(cur);
                    checks++;
                    if (s_bus.valid !== 1'b1 || s_bus.addr !== h.addr || s_bus.wdata !== h.wdata ||
                        s_bus.wstrb !== h.wstrb || grant !== (cur == 1 ? 2'b10 : 2'b01)) begin
                        failures++;
                        $display("FAIL hold: s_valid=%b addr=%h grant=%b, want 1 addr=%h owner m%0d",
                                 s_bus.valid, s_bus.addr, grant, h.addr, cur);
                    end
                end else if (s_bus.valid === 1'b1) begin
                    checks++;
                    if (!s0 && !s1) begin
                        failures++;
                        $display("FAIL unexpected_grant: s_valid=1 grant=%b, want no transfer", grant);
                    end else begin
                        cur = (s0 && s1) ? 1 - lastw : (s1 ? 1 : 0);
                        lastw = cur;
                        grant_log.push_back(cur);
                        h = head(cur);
                        if (s_bus.addr !== h.addr || s_bus.wdata !== h.wdata || s_bus.wstrb !== h.wstrb ||
                            grant !== (cur == 1 ? 2'b10 : 2'b01)) begin
                            failures++;
                            $display("FAIL grant: addr=%h wdata=%h wstrb=%h grant=%b, want addr=%h wdata=%h wstrb=%h owner m%0d",
                                     s_bus.addr, s_bus.wdata, s_bus.wstrb, grant, h.addr, h.wdata, h.wstrb, cur);
                        end
                        busy = 1; bidx = 0;
                        lat = int'($urandom_range(maxlat, minlat));
                    end
                end
            end
            s_bus.ready = 1'b0;
            if (busy) begin
                if (bidx == lat && lat < TO) begin
                    exp_rd = fix_en ? fix_val : $urandom;
                    s_bus.ready = 1'b1; s_bus.rdata = exp_rd;
                    resp_err = 0; resp_due = 1; busy = 0;
                end else if (bidx == TO - 1) begin
                    exp_rd = ERRD; resp_err = 1; errs++;
                    resp_due = 1; busy = 0;
                end
            end
            drive_masters(gaps);
        end
        s_bus.ready = 1'b0;
        if (cyc >= budget) begin
            checks++; failures++;
            $display("FAIL traffic_budget: ran %0d cycles, want completion within %0d", cyc, budget);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (s_bus.valid !== 1'b0 || s_bus.addr !== '0 || s_bus.wdata !== '0 || s_bus.wstrb !== '0) begin
            failures++;
            $display("FAIL reset_slave: valid=%b addr=%h wdata=%h wstrb=%h, want all 0",
                     s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb);
        end
        checks++;
        if (m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0 || m0_bus.rdata !== '0 || m1_bus.rdata !== '0) begin
            failures++;
            $display("FAIL reset_master: ready=%b%b rdata=%h/%h, want all 0",
                     m0_bus.ready, m1_bus.ready, m0_bus.rdata, m1_bus.rdata);
        end
        checks++;
        if (grant !== 2'b00 || err !== 1'b0 || err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_status: grant=%b err=%b cnt=%0d, want 0 0 0", grant, err, err_count);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        s_bus.ready = 1'b1; s_bus.rdata = 32'h1234_5678;
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h1000_0000; m0_bus.wdata = 32'h0000_0005; m0_bus.wstrb = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (s_bus.valid !== 1'b1 || s_bus.addr !== 32'h1000_0000 || s_bus.wdata !== 32'h5 ||
            s_bus.wstrb !== 4'hF || grant !== 2'b01 || m0_bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL single_busy: s_valid=%b addr=%h wdata=%h wstrb=%h grant=%b m0_ready=%b, want 1 10000000 5 f 01 0",
                     s_bus.valid, s_bus.addr, s_bus.wdata, s_bus.wstrb, grant, m0_bus.ready);
        end
        @(posedge clk); #1;
        checks++;
        if (m0_bus.ready !== 1'b1 || m1_bus.ready !== 1'b0 || s_bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL single_resp: m0_ready=%b m1_ready=%b s_valid=%b, want 1 0 0",
                     m0_bus.ready, m1_bus.ready, s_bus.valid);
        end
        m0_bus.valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (m0_bus.ready !== 1'b0 || grant !== 2'b00 || s_bus.valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle: m0_ready=%b grant=%b s_valid=%b, want 0 00 0",
                     m0_bus.ready, grant, s_bus.valid);
        end
        s_bus.ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        do_reset();
        grant_log.delete(); rdy_cnt[0] = 0; rdy_cnt[1] = 0;
        for (int i = 0; i < 4; i++) begin
            q0.push_back(rand_req());
            q1.push_back(rand_req());
        end
        run_traffic(0, 0, 1'b0, 1'b0, '0, 100);
        checks++;
        if (grant_log.size() != 8) begin
            failures++;
            $display("FAIL contention_count: grants=%0d, want 8", grant_log.size());
        end
        for (int i = 0; i < grant_log.size(); i++) begin
            checks++;
            if (grant_log[i] != (i % 2)) begin
                failures++;
                $display("FAIL contention_order[%0d]: got m%0d, want m%0d", i, grant_log[i], i % 2);
            end
        end
        checks++;
        if (rdy_cnt[0] != 4 || rdy_cnt[1] != 4) begin
            failures++;
            $display("FAIL contention_ready: m0=%0d m1=%0d, want 4 4", rdy_cnt[0], rdy_cnt[1]);
        end
    endtask

    task automatic test_read_wait();
        req_t r;
        logic [31:0] m0_before;
        m0_before = m0_bus.rdata;
        r.addr = 32'h1000_0004; r.wdata = $urandom; r.wstrb = 4'h0;
        q1.push_back(r);
        run_traffic(3, 3, 1'b0, 1'b1, 32'hCAFE_0001, 50);
        checks++;
        if (m1_bus.rdata !== 32'hCAFE_0001 || m0_bus.rdata !== m0_before) begin
            failures++;
            $display("FAIL read_wait: m1_rdata=%h m0_rdata=%h, want cafe0001 %h",
                     m1_bus.rdata, m0_bus.rdata, m0_before);
        end
    endtask

    task automatic test_ready_last();
        int errs_before;
        errs_before = errs;
        q0.push_back(rand_req());
        run_traffic(TO - 1, TO - 1, 1'b0, 1'b0, '0, 50);
        checks++;
        if (err_count !== 8'(errs_before)) begin
            failures++;
            $display("FAIL ready_last: err_count=%0d, want %0d", err_count, errs_before);
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        int cyc = 0;
        do_reset();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h1000_0008; m0_bus.wdata = $urandom; m0_bus.wstrb = 4'h3;
        while (m0_bus.ready !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
            if (s_bus.valid === 1'b1) hi++;
        end
        m0_bus.valid = 1'b0;
        checks++;
        if (hi != TO || m0_bus.ready !== 1'b1) begin
            failures++;
            $display("FAIL timeout_len: s_valid cycles=%0d ready=%b, want %0d 1", hi, m0_bus.ready, TO);
        end
        checks++;
        if (m0_bus.rdata !== ERRD || err !== 1'b1 || err_count !== 8'd1) begin
            failures++;
            $display("FAIL timeout_resp: rdata=%h err=%b cnt=%0d, want ffffffff 1 1",
                     m0_bus.rdata, err, err_count);
        end
        @(posedge clk); #1;
        checks++;
        if (err !== 1'b0 || m0_bus.ready !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: err=%b ready=%b, want 0 0", err, m0_bus.ready);
        end
        errs = 1;
        rd_model[0] = ERRD;
        for (int i = 0; i < 299; i++) q0.push_back(rand_req());
        run_traffic(100, 100, 1'b0, 1'b0, '0, 299 * (TO + 3) + 100);
        checks++;
        if (err_count !== 8'hFF) begin
            failures++;
            $display("FAIL timeout_saturate: err_count=%0d, want 255", err_count);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < int'($urandom_range(20, 10)); i++) q0.push_back(rand_req());
        for (int i = 0; i < int'($urandom_range(20, 10)); i++) q1.push_back(rand_req());
        run_traffic(0, TO + 2, 1'b1, 1'b0, '0, 3000);
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_bus.valid = 1'b1; m0_bus.addr = 32'h1000_0010; m0_bus.wdata = $urandom; m0_bus.wstrb = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (s_bus.valid !== 1'b0 || s_bus.addr !== '0 || m0_bus.ready !== 1'b0 || m1_bus.ready !== 1'b0 ||
            grant !== 2'b00 || err !== 1'b0 || m0_bus.rdata !== '0) begin
            failures++;
            $display("FAIL reset_mid: s_valid=%b addr=%h ready=%b%b grant=%b err=%b, want all 0",
                     s_bus.valid, s_bus.addr, m0_bus.ready, m1_bus.ready, grant, err);
        end
        rst = 1'b0;
        m0_bus.addr = 32'h1000_0020;
        m1_bus.valid = 1'b1; m1_bus.addr = 32'h1000_0030; m1_bus.wdata = $urandom; m1_bus.wstrb = 4'h1;
        @(posedge clk); #1;
        checks++;
        if (s_bus.valid !== 1'b1 || grant !== 2'b01 || s_bus.addr !== 32'h1000_0020) begin
            failures++;
            $display("FAIL reset_mid_first: s_valid=%b grant=%b addr=%h, want 1 01 10000020",
                     s_bus.valid, grant, s_bus.addr);
        end
        do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_read_wait();
        test_ready_last();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_arbiter.md
# mmio_arbiter

Two-master arbiter sharing the single 32-bit valid/ready MMIO bus between the CPU (master 0) and a secondary requester (master 1, e.g. a stimulus or debug driver), in front of the peripheral decoder (PWM duty register at 0x1000_0000 and others). Grants round-robin and latches the winner's request onto the slave port. Returns slave read data only to the granted master. Aborts hung transfers with a timeout and reports them through an error pulse and a counter.

## Interface
- TIMEOUT, 1024: max BUSY cycles without s_ready before abort (≥2)
- ERR_RDATA, 32'hFFFF_FFFF: read data returned on a timed-out transfer
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- m0_valid / m1_valid  in  1  master request
- m0_addr / m1_addr  in  32  byte address
- m0_wdata / m1_wdata  in  32  write data
- m0_wstrb / m1_wstrb  in  4  byte strobes; 0 = read
- m0_ready / m1_ready  out  1  one-cycle completion pulse
- m0_rdata / m1_rdata  out  32  read data, valid while own ready=1
- s_valid  out  1  request to slave
- s_addr, s_wdata  out  32  latched request
- s_wstrb  out  4  latched strobes
- s_rdata  in  32  slave read data, sampled when s_ready=1
- s_ready  in  1  slave completion, may be combinational from s_valid
- grant  out  2  one-hot owner, 0 when idle
- err  out  1  one-cycle pulse on timeout abort
- err_count  out  8  saturating count of aborts

## Operation
- All outputs registered. Reset value of every output is 0. Internal state: IDLE, last_grant=1 (so m0 wins first), timeout counter 0.
- IDLE: if exactly one valid, grant it. If both valid, grant the master ≠ last_grant. On grant, latch addr/wdata/wstrb to s_*, set s_valid=1, set grant one-hot, update last_grant, clear counter, go BUSY.
- BUSY: s_* held stable.
  - s_ready=1: capture s_rdata into the granted mX_rdata, set mX_ready=1, s_valid=0, go RESP.
  - Else if counter==TIMEOUT-1: mX_rdata=ERR_RDATA, mX_ready=1, s_valid=0, err=1, err_count+1 (saturates at 255), go RESP.
  - Else counter+1.
  - s_ready on the final timeout cycle counts as normal completion, no error.
- RESP: mX_ready and err return to 0, grant=0, go IDLE. The master drops valid on the edge where it sees ready, so IDLE never re-samples the completed request.
- Non-granted master's ready stays 0 and its rdata holds its last value. Its request remains pending and is taken on the next IDLE.
- Master valid dropping while BUSY has no effect; the latched transfer completes.
- rst mid-transfer: all outputs return to 0 on that edge, the transfer is abandoned, no ready is issued, state IDLE, last_grant=1.

## Timing
- Master valid first high in cycle c → s_valid high in c+1.
- Zero-wait slave (s_ready in c+1) → mX_ready high in c+2 → IDLE in c+3.
- Next s_valid no earlier than c+4: 3 cycles per transfer minimum.
- Each slave wait cycle adds one cycle.
- Timeout: s_valid high for exactly TIMEOUT cycles. mX_ready and err appear in the cycle after the last of them.
- Fairness: under continuous contention, grants strictly alternate m0, m1, m0, …

## Test plan
- Reset release, m0 writes 0x0000_0005 to 0x1000_0000, wstrb=F, slave ready immediately → s_valid for 1 cycle carrying that address/data; m0_ready one pulse 2 cycles after valid; grant=01 during BUSY; m1_ready stays 0.
- m0 and m1 both assert valid in the same cycle, 4 transfers each, always pending → s_addr sequence alternates m0,m1,m0,m1…, m0 first; each master receives exactly 4 ready pulses.
- m1 read (wstrb=0) from 0x1000_0004, slave waits 3 cycles then returns 0xCAFE_0001 → m1_rdata=0xCAFE_0001 while m1_ready=1; m0_rdata unchanged; s_* stable throughout the wait.
- TIMEOUT=8, slave never ready → s_valid high exactly 8 cycles; m0_ready=1 with m0_rdata=FFFF_FFFF; err pulses once; err_count=1. Repeat 300 times → err_count saturates at 255.
- Slave asserts s_ready exactly on cycle TIMEOUT → normal completion with slave data; err=0; err_count unchanged.
- rst asserted 2 cycles into a BUSY wait → next cycle all outputs 0, no ready pulse; after release with both requesting, m0 granted first.
